// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: fixed priority with per-requester aging,
// a registered write stage, and a pending-destination scoreboard for hazard stalls.

module rf_age_ctr #(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = $clog2(STARVE_LIMIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic valid,
  input  logic ready,
  output logic starved
);
  localparam logic [AW-1:0] LIM = AW'(STARVE_LIMIT);

  logic [AW-1:0] age;

  // Age only builds while a request sits valid and ungranted; it saturates at the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        age <= '0;
    else if (flush || !valid || ready) age <= '0;
    else if (age != LIM)              age <= age + 1'b1;
  end

  assign starved = valid && (age == LIM);
endmodule

module rf_write_arbiter #(
  parameter int XLEN         = 32,
  parameter int NUM_REQ      = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*5-1:0]    req_rd,
  input  logic [NUM_REQ*XLEN-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic                    issue_valid,
  input  logic [4:0]              issue_rd,
  output logic                    issue_ready,
  input  logic [4:0]              rs1,
  input  logic [4:0]              rs2,
  output logic                    stall_rs1,
  output logic                    stall_rs2,
  output logic                    rf_we,
  output logic [4:0]              rf_waddr,
  output logic [XLEN-1:0]         rf_wdata,
  output logic [31:0]             pending
);
  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  logic [NUM_REQ-1:0] starved;
  logic [NUM_REQ-1:0] grant;
  logic               hit;
  wb_req_t            sel;
  logic               hs;
  logic [31:0]        pend_nxt;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_age
      rf_age_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_age (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .valid  (req_valid[gi]),
        .ready  (req_ready[gi]),
        .starved(starved[gi])
      );
    end
  endgenerate

  // Starved requesters pre-empt plain priority; lowest index wins inside either group.
  always_comb begin
    grant = '0;
    hit   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (!hit && starved[i]) begin
        grant[i] = 1'b1;
        hit      = 1'b1;
      end
    for (int i = 0; i < NUM_REQ; i++)
      if (!hit && req_valid[i]) begin
        grant[i] = 1'b1;
        hit      = 1'b1;
      end
  end

  assign req_ready = (flush || reset) ? '0 : grant;
  assign hs        = |(req_valid & req_ready);

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (req_ready[i]) begin
        sel.rd   = sel.rd   | req_rd[5*i +: 5];
        sel.data = sel.data | req_data[XLEN*i +: XLEN];
      end
  end

  // x0 writes are accepted but never reach the register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= hs && (sel.rd != 5'd0);
      if (hs && (sel.rd != 5'd0)) begin
        rf_waddr <= sel.rd;
        rf_wdata <= sel.data;
      end
    end
  end

  assign issue_ready = (issue_rd == 5'd0) || !pending[issue_rd];
  assign stall_rs1   = (rs1 != 5'd0) && pending[rs1];
  assign stall_rs2   = (rs2 != 5'd0) && pending[rs2];

  // Set is applied after clear so a same-edge reservation survives the retiring write.
  always_comb begin
    pend_nxt = pending;
    if (rf_we) pend_nxt[rf_waddr] = 1'b0;
    if (issue_valid && issue_ready && (issue_rd != 5'd0)) pend_nxt[issue_rd] = 1'b1;
    if (flush) pend_nxt = '0;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= pend_nxt;
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized + directed bench for rf_write_arbiter against a cycle-level reference model.

module tb_rf_write_arbiter;
  localparam int XLEN = 32;
  localparam int NR   = 3;
  localparam int L    = 4;

  logic            clk, reset, flush;
  logic [NR-1:0]   req_valid;
  logic [NR*5-1:0] req_rd;
  logic [NR*XLEN-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            issue_valid;
  logic [4:0]      issue_rd, rs1, rs2;
  logic            issue_ready, stall_rs1, stall_rs2;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [31:0]     pending;

  rf_write_arbiter #(.XLEN(XLEN), .NUM_REQ(NR), .STARVE_LIMIT(L)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2), .stall_rs1(stall_rs1), .stall_rs2(stall_rs2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // requester-side state: a request is held until it is granted
  logic        rq_v[NR];
  logic [4:0]  rq_rd[NR];
  logic [31:0] rq_d[NR];
  logic        fl, iv;
  logic [4:0]  ird, r1, r2;

  // reference model state
  int          age_m[NR];
  logic [31:0] m_pend;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [NR-1:0] last_rdy;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick();
    int q[$];
    if (fl) return -1;
    for (int i = 0; i < NR; i++) if (rq_v[i] && age_m[i] == L) q.push_back(i);
    if (q.size() > 0) return q[0];
    for (int i = 0; i < NR; i++) if (rq_v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) age_m[i] = 0;
    m_pend = 0; m_we = 0; m_waddr = 0; m_wdata = 0;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < NR; i++) begin rq_v[i] = 0; rq_rd[i] = 0; rq_d[i] = 0; end
    fl = 0; iv = 0; ird = 0; r1 = 0; r2 = 0;
  endtask

  // Called just after a falling edge: drive, check, advance model, wait one cycle.
  task automatic step();
    int g;
    logic [NR-1:0] exp_rdy;
    logic exp_ir, new_we;
    logic [4:0] new_a;
    logic [31:0] new_d;
    for (int i = 0; i < NR; i++) begin
      req_valid[i]         = rq_v[i];
      req_rd[5*i +: 5]     = rq_rd[i];
      req_data[32*i +: 32] = rq_d[i];
    end
    flush = fl; issue_valid = iv; issue_rd = ird; rs1 = r1; rs2 = r2;
    #1;
    g = pick();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    exp_ir = (ird == 0) || !m_pend[ird];
    chk("rf_we", rf_we, m_we);
    if (m_we) begin
      chk("rf_waddr", rf_waddr, m_waddr);
      chk("rf_wdata", rf_wdata, m_wdata);
    end
    chk("pending", pending, m_pend);
    chk("req_ready", req_ready, exp_rdy);
    chk("issue_ready", issue_ready, exp_ir);
    chk("stall_rs1", stall_rs1, (r1 != 0) && m_pend[r1]);
    chk("stall_rs2", stall_rs2, (r2 != 0) && m_pend[r2]);
    last_rdy = req_ready;

    new_we = (g >= 0) && (rq_rd[g] != 0);
    new_a  = new_we ? rq_rd[g] : m_waddr;
    new_d  = new_we ? rq_d[g]  : m_wdata;
    if (fl) m_pend = 0;
    else begin
      if (m_we) m_pend[m_waddr] = 1'b0;
      if (iv && exp_ir && ird != 0) m_pend[ird] = 1'b1;
    end
    for (int i = 0; i < NR; i++)
      if (fl || !rq_v[i] || i == g) age_m[i] = 0;
      else if (age_m[i] < L) age_m[i]++;
    if (g >= 0) rq_v[g] = 1'b0;
    m_we = new_we; m_waddr = new_a; m_wdata = new_d;
    @(negedge clk);
  endtask

  int alu_win;

  initial begin
    idle_inputs();
    model_reset();
    req_valid = '0; req_rd = '0; req_data = '0;
    flush = 0; issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
    reset = 1'b1;
    #1;
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_pending", pending, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // single ALU write
    rq_v[2] = 1; rq_rd[2] = 5; rq_d[2] = 32'hDEADBEEF;
    step(); step(); step();

    // load beats ALU, ALU follows next cycle
    rq_v[0] = 1; rq_rd[0] = 3; rq_d[0] = 32'h1111;
    rq_v[2] = 1; rq_rd[2] = 4; rq_d[2] = 32'h2222;
    step(); step(); step();

    // starvation: continuous loads, ALU must win in cycle 4
    alu_win = -1;
    rq_v[2] = 1; rq_rd[2] = 9; rq_d[2] = 32'h9999;
    for (int c = 0; c < 7; c++) begin
      rq_v[0] = 1; rq_rd[0] = 5'(10 + c); rq_d[0] = 32'(c);
      step();
      if (last_rdy[2] && alu_win < 0) alu_win = c;
    end
    chk("starve_cycle", alu_win, 4);
    rq_v[0] = 0;
    step(); step();

    // x0 write accepted, no register write
    rq_v[2] = 1; rq_rd[2] = 0; rq_d[2] = 32'h1234;
    step(); step();

    // scoreboard RAW/WAW
    iv = 1; ird = 7; step();
    iv = 1; ird = 7; r1 = 7; step();
    iv = 0; rq_v[2] = 1; rq_rd[2] = 7; rq_d[2] = 32'h77; step();
    step(); step();
    chk("stall_dropped", stall_rs1, 0);

    // async reset while a write is in flight and r7 pending
    iv = 1; ird = 7; r1 = 0; step();
    iv = 0; rq_v[2] = 1; rq_rd[2] = 7; rq_d[2] = 32'h55; step();
    chk("pre_rst_we", rf_we, 1);
    chk("pre_rst_pend", pending, 32'h80);
    rq_v[0] = 1; rq_rd[0] = 2; req_valid = 3'b001; req_rd = 15'd2;
    reset = 1'b1;
    #1;
    chk("mid_rst_we", rf_we, 0);
    chk("mid_rst_pend", pending, 0);
    chk("mid_rst_ready", req_ready, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // flush blocks grant and clears scoreboard
    rq_v[0] = 0; iv = 1; ird = 12; step();
    iv = 0; fl = 1; rq_v[0] = 1; rq_rd[0] = 6; rq_d[0] = 32'hF00D; step();
    fl = 0; step(); step();

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NR; i++)
        if (!rq_v[i] && $urandom_range(1, 0) == 1) begin
          rq_v[i]  = 1;
          rq_rd[i] = 5'($urandom_range(9, 0));
          rq_d[i]  = $urandom;
        end
      fl  = ($urandom_range(19, 0) == 0);
      iv  = $urandom_range(1, 0) == 1;
      ird = 5'($urandom_range(9, 0));
      r1  = 5'($urandom_range(9, 0));
      r2  = 5'($urandom_range(9, 0));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
